// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core pipeline control logic:
// stage indices and the stall/flush sequencer state encoding.
package core_ctrl_pkg;

   localparam int unsigned NUM_STAGES = 5;

   localparam int unsigned STAGE_IF  = 0;
   localparam int unsigned STAGE_ID  = 1;
   localparam int unsigned STAGE_EX  = 2;
   localparam int unsigned STAGE_MEM = 3;
   localparam int unsigned STAGE_WB  = 4;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MDU_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/stall_prio_encoder.sv
// Turns a per-stage hold request vector into a thermometer stall mask:
// every stage at or before the latest requesting stage is stalled.
module stall_prio_encoder
   import core_ctrl_pkg::*;
(
   input  logic [NUM_STAGES-1:0] req,
   output logic [NUM_STAGES-1:0] mask
);

   always_comb begin
      mask = '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
         mask[k] = |(req >> k);
      end
   end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage core: merges stage stall requests,
// times multi-cycle mul/div ops and sequences exception flushes.
module pipeline_controller
   import core_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned MDU_LATENCY = 32,
   parameter int unsigned CNT_WIDTH   = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_STAGES-1:0] stall_req,
   input  logic                  mdu_start,
   input  logic                  exc_req,
   input  logic [ADDR_WIDTH-1:0] exc_pc,
   output logic [NUM_STAGES-1:0] stall,
   output logic                  flush,
   output logic [ADDR_WIDTH-1:0] flush_pc,
   output logic                  mdu_busy,
   output logic                  mdu_done,
   output logic [31:0]           stall_count
);

   // Remaining MDU_WAIT cycles after the start cycle, minus one.
   localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
      (MDU_LATENCY > 1) ? CNT_WIDTH'(MDU_LATENCY - 2) : '0;

   ctrl_state_t           state, state_next;
   logic [CNT_WIDTH-1:0]  cnt, cnt_next;
   logic [ADDR_WIDTH-1:0] flush_pc_next;
   logic                  mdu_hold;
   logic [NUM_STAGES-1:0] stall_src;
   logic [NUM_STAGES-1:0] stall_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         cnt         <= '0;
         flush_pc    <= '0;
         stall_count <= '0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         flush_pc <= flush_pc_next;
         if (stall[STAGE_IF] && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end

   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      flush_pc_next = flush_pc;
      mdu_hold      = 1'b0;
      mdu_busy      = 1'b0;
      mdu_done      = 1'b0;

      case (state)
         ST_RUN: begin
            if (mdu_start) begin
               mdu_busy = 1'b1;
               if (MDU_LATENCY > 1) begin
                  mdu_hold   = 1'b1;
                  state_next = ST_MDU_WAIT;
                  cnt_next   = CNT_LOAD;
               end else begin
                  mdu_done = 1'b1;
               end
            end
         end
         ST_MDU_WAIT: begin
            mdu_busy = 1'b1;
            mdu_hold = 1'b1;
            if (cnt == '0) begin
               mdu_done   = 1'b1;
               state_next = ST_RUN;
            end else begin
               cnt_next = cnt - CNT_WIDTH'(1);
            end
         end
         ST_FLUSH: state_next = ST_RUN;
         default:  state_next = ST_RUN;
      endcase

      // An exception aborts any MDU op and wins over every other transition.
      if (exc_req) begin
         state_next    = ST_FLUSH;
         flush_pc_next = exc_pc;
         cnt_next      = '0;
         mdu_done      = 1'b0;
      end

      if (rst) begin
         mdu_busy = 1'b0;
         mdu_done = 1'b0;
      end

      stall_src           = stall_req;
      stall_src[STAGE_EX] = stall_req[STAGE_EX] | mdu_hold;
      stall               = (rst || (state == ST_FLUSH)) ? '0 : stall_mask;
   end

   assign flush = (state == ST_FLUSH);

   stall_prio_encoder u_prio (
      .req  (stall_src),
      .mask (stall_mask)
   );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller (MDU_LATENCY=4) with an
// expectation queue popped and compared once per cycle.
module tb_pipeline_controller;

   logic        clk;
   logic        rst;
   logic [4:0]  stall_req;
   logic        mdu_start;
   logic        exc_req;
   logic [31:0] exc_pc;
   logic [4:0]  stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        mdu_busy;
   logic        mdu_done;
   logic [31:0] stall_count;

   typedef struct {
      string       tag;
      logic [4:0]  stall;
      logic        flush;
      logic [31:0] fpc;
      logic        busy;
      logic        done;
      logic [31:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] cnt_model = 0;
   logic [31:0] fpc_model = 0;

   localparam logic [31:0] PC_EXC = 32'hBFC0_0380;
   localparam logic [31:0] PC_A   = 32'h8000_0100;
   localparam logic [31:0] PC_B   = 32'h8000_0200;

   pipeline_controller #(
      .ADDR_WIDTH  (32),
      .MDU_LATENCY (4),
      .CNT_WIDTH   (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_req   (stall_req),
      .mdu_start   (mdu_start),
      .exc_req     (exc_req),
      .exc_pc      (exc_pc),
      .stall       (stall),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .mdu_busy    (mdu_busy),
      .mdu_done    (mdu_done),
      .stall_count (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input string field,
                        input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s.%s: observed %h expected %h", tag, field, obs, exp);
      end
   endtask

   task automatic compare_all(input exp_t e);
      check(e.tag, "stall",       32'(stall),    32'(e.stall));
      check(e.tag, "flush",       32'(flush),    32'(e.flush));
      check(e.tag, "flush_pc",    flush_pc,      e.fpc);
      check(e.tag, "mdu_busy",    32'(mdu_busy), 32'(e.busy));
      check(e.tag, "mdu_done",    32'(mdu_done), 32'(e.done));
      check(e.tag, "stall_count", stall_count,   e.cnt);
   endtask

   // One clock cycle: drive inputs, queue the expectation, compare at negedge.
   task automatic cyc(input string tag, input logic [4:0] sr, input logic ms,
                      input logic er, input logic [31:0] epc,
                      input logic [4:0] e_stall, input logic e_flush,
                      input logic e_busy, input logic e_done);
      exp_t e;
      stall_req = sr;
      mdu_start = ms;
      exc_req   = er;
      exc_pc    = epc;
      e.tag   = tag;
      e.stall = e_stall;
      e.flush = e_flush;
      e.fpc   = fpc_model;
      e.busy  = e_busy;
      e.done  = e_done;
      e.cnt   = cnt_model;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         compare_all(sb_q.pop_front());
      end
      if (e_stall[0]) cnt_model = cnt_model + 1;
      if (er) fpc_model = epc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t r;
      rst       = 1'b1;
      stall_req = '0;
      mdu_start = 1'b0;
      exc_req   = 1'b0;
      exc_pc    = '0;
      #3;
      r.tag = "reset"; r.stall = '0; r.flush = 1'b0; r.fpc = '0;
      r.busy = 1'b0; r.done = 1'b0; r.cnt = '0;
      compare_all(r);
      #9 rst = 1'b0;
      @(posedge clk);
      #1;

      // Later-stage stall request stalls everything upstream.
      cyc("t1_c1", 5'b01000, 0, 0, 0, 5'b01111, 0, 0, 0);
      cyc("t1_c2", 5'b01000, 0, 0, 0, 5'b01111, 0, 0, 0);
      cyc("t1_c3", 5'b01000, 0, 0, 0, 5'b01111, 0, 0, 0);
      cyc("t1_idle", 5'b00000, 0, 0, 0, 5'b00000, 0, 0, 0);

      // MDU op holds IF..EX for 4 cycles.
      cyc("t2_start", 5'b00000, 1, 0, 0, 5'b00111, 0, 1, 0);
      cyc("t2_w1",    5'b00000, 0, 0, 0, 5'b00111, 0, 1, 0);
      cyc("t2_w2",    5'b00000, 0, 0, 0, 5'b00111, 0, 1, 0);
      cyc("t2_done",  5'b00000, 0, 0, 0, 5'b00111, 0, 1, 1);
      cyc("t2_after", 5'b00000, 0, 0, 0, 5'b00000, 0, 0, 0);

      // MEM stall mid-op and a repeated start do not shift completion.
      cyc("t3_start", 5'b00000, 1, 0, 0, 5'b00111, 0, 1, 0);
      cyc("t3_memst", 5'b01000, 0, 0, 0, 5'b01111, 0, 1, 0);
      cyc("t3_restr", 5'b00000, 1, 0, 0, 5'b00111, 0, 1, 0);
      cyc("t3_done",  5'b00000, 0, 0, 0, 5'b00111, 0, 1, 1);
      cyc("t3_after", 5'b00000, 0, 0, 0, 5'b00000, 0, 0, 0);

      // Exception aborts an MDU op.
      cyc("t4_start", 5'b00000, 1, 0, 0,      5'b00111, 0, 1, 0);
      cyc("t4_exc",   5'b00000, 0, 1, PC_EXC, 5'b00111, 0, 1, 0);
      cyc("t4_flush", 5'b00000, 0, 0, 0,      5'b00000, 1, 0, 0);
      cyc("t4_after", 5'b00000, 0, 0, 0,      5'b00000, 0, 0, 0);
      cyc("t4_idle",  5'b00000, 0, 0, 0,      5'b00000, 0, 0, 0);

      // Back-to-back exceptions; requests are masked during flush.
      cyc("t5_excA",  5'b00000, 0, 1, PC_A, 5'b00000, 0, 0, 0);
      cyc("t5_excB",  5'b11111, 0, 1, PC_B, 5'b00000, 1, 0, 0);
      cyc("t5_flshB", 5'b00000, 0, 0, 0,    5'b00000, 1, 0, 0);
      cyc("t5_after", 5'b00000, 0, 0, 0,    5'b00000, 0, 0, 0);

      // Exception in the last MDU cycle suppresses mdu_done.
      cyc("t5b_start", 5'b00000, 1, 0, 0,    5'b00111, 0, 1, 0);
      cyc("t5b_w1",    5'b00000, 0, 0, 0,    5'b00111, 0, 1, 0);
      cyc("t5b_w2",    5'b00000, 0, 0, 0,    5'b00111, 0, 1, 0);
      cyc("t5b_last",  5'b00000, 0, 1, PC_A, 5'b00111, 0, 1, 0);
      cyc("t5b_flush", 5'b00000, 0, 0, 0,    5'b00000, 1, 0, 0);

      // Async reset in the middle of an MDU op.
      cyc("t6_start", 5'b00000, 1, 0, 0, 5'b00111, 0, 1, 0);
      stall_req = '0;
      mdu_start = 1'b0;
      #1 rst = 1'b1;
      #1;
      cnt_model = 0;
      fpc_model = 0;
      r.tag = "t6_rst"; r.stall = '0; r.flush = 1'b0; r.fpc = '0;
      r.busy = 1'b0; r.done = 1'b0; r.cnt = '0;
      compare_all(r);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      cyc("t6_idle",  5'b00000, 0, 0, 0, 5'b00000, 0, 0, 0);
      cyc("t6_start", 5'b00000, 1, 0, 0, 5'b00111, 0, 1, 0);
      cyc("t6_w1",    5'b00000, 0, 0, 0, 5'b00111, 0, 1, 0);
      cyc("t6_w2",    5'b00000, 0, 0, 0, 5'b00111, 0, 1, 0);
      cyc("t6_done",  5'b00000, 0, 0, 0, 5'b00111, 0, 1, 1);
      cyc("t6_after", 5'b00000, 0, 0, 0, 5'b00000, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
